pid_output_limiter: RTL and testbench



---
 rtl/pid_output_limiter_if.sv | 41 ++++
 rtl/pid_output_limiter.sv | 234 +++++++++++++++++++++++
 tb/tb_pid_output_limiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pid_output_limiter_if.sv
// -----------------------------------------------------------------------------
// pid_output_limiter_if
// Sample stream between the PID/transfer-function core and the output limiter.
//   sta       : one-cycle start-of-step pulse (producer -> limiter)
//   in_valid  : din carries a channel sample (producer -> limiter)
//   din       : IEEE-754 single sample (producer -> limiter)
//   y         : clamped sample (limiter -> consumer)
//   out_valid : y, ch_idx and flags are valid (limiter -> consumer)
//   ch_idx    : channel index of y (limiter -> consumer)
//   sat_hi    : sample clamped to the upper limit
//   sat_lo    : sample clamped to the lower limit, or was NaN
//   nan_err   : sticky NaN indicator, cleared only by reset
//   sat_cnt   : saturated-sample count of the last completed step
//   done_sig  : one-cycle pulse with the last sample of a step
// Modports: master = sample producer / result consumer side, slave = limiter.
// -----------------------------------------------------------------------------
interface pid_output_limiter_if #(
  parameter int CH_W = 6
);
  logic            sta;
  logic            in_valid;
  logic [31:0]     din;
  logic [31:0]     y;
  logic            out_valid;
  logic [CH_W-1:0] ch_idx;
  logic            sat_hi;
  logic            sat_lo;
  logic            nan_err;
  logic [15:0]     sat_cnt;
  logic            done_sig;

  modport master (
    output sta, in_valid, din,
    input  y, out_valid, ch_idx, sat_hi, sat_lo, nan_err, sat_cnt, done_sig
  );

  modport slave (
    input  sta, in_valid, din,
    output y, out_valid, ch_idx, sat_hi, sat_lo, nan_err, sat_cnt, done_sig
  );
endinterface

// File: rtl/pid_output_limiter.sv
// -----------------------------------------------------------------------------
// pid_output_limiter
// Clamps the serial stream of IEEE-754 single-precision PID outputs (one per
// wind-turbine channel per solver step) to [LO, HI], tags each sample with its
// channel index, flags saturation / NaN and pulses done_sig with the last
// channel of a step. Two-cycle pipeline, one sample per cycle, bubbles allowed.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : pid_output_limiter_if.slave (sta/in_valid/din in, results out)
// -----------------------------------------------------------------------------
module pid_output_limiter #(
  parameter int          N_CH = 32,
  parameter int          CH_W = 6,
  parameter logic [31:0] HI   = 32'h3F800000,
  parameter logic [31:0] LO   = 32'hBF800000
) (
  input  logic                 clk,
  input  logic                 rst,
  pid_output_limiter_if.slave  bus
);

  // Monotonic unsigned ordering key for IEEE-754 singles. Both zeros map to the
  // same key so that -0 and +0 compare equal; every other value orders naturally.
  function automatic logic [31:0] f_key(input logic [31:0] b);
    logic [31:0] k;
    if (b[30:0] == 31'd0) begin
      k = 32'h8000_0000;
    end else if (b[31]) begin
      k = ~b;
    end else begin
      k = {1'b1, b[30:0]};
    end
    return k;
  endfunction

  localparam logic [31:0]     KEY_HI  = f_key(HI);
  localparam logic [31:0]     KEY_LO  = f_key(LO);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CH_W-1:0] r_ch_cnt;
  logic [CH_W-1:0] w_ch_next;
  logic [CH_W-1:0] w_cur_ch;
  logic            w_accept;
  logic            w_last;

  // Stage 1
  logic            r_s1_valid;
  logic            r_s1_nan;
  logic            r_s1_last;
  logic [31:0]     r_s1_din;
  logic [31:0]     r_s1_key;
  logic [CH_W-1:0] r_s1_ch;
  logic [31:0]     w_din_key;
  logic            w_din_nan;

  // Stage 2 / outputs
  logic [31:0]     r_y;
  logic            r_out_valid;
  logic [CH_W-1:0] r_ch_idx;
  logic            r_sat_hi;
  logic            r_sat_lo;
  logic            r_nan_err;
  logic            r_done;
  logic [15:0]     r_run_cnt;
  logic [15:0]     r_sat_cnt;

  logic            w_gt_hi;
  logic            w_lt_lo;
  logic            w_sat_hi;
  logic            w_sat_lo;
  logic [31:0]     w_y;
  logic            w_sat_any;
  logic [15:0]     w_run_inc;
  logic            w_done_set;

  // ---------------------------------------------------------------------------
  // Acceptance and channel numbering
  // ---------------------------------------------------------------------------
  // A start pulse opens a step on the same cycle, so a sample arriving together
  // with sta is taken as channel 0 whatever state the FSM is in.
  assign w_accept = bus.in_valid && (bus.sta || (r_state == S_RUN));
  assign w_cur_ch = bus.sta ? '0 : r_ch_cnt;
  assign w_last   = w_accept && (w_cur_ch == LAST_CH);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ch_cnt <= '0;
    end else begin
      r_state  <= w_state_next;
      r_ch_cnt <= w_ch_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ch_next    = r_ch_cnt;

    if (bus.sta) begin
      w_ch_next = '0;
    end
    if (w_accept) begin
      w_ch_next = w_cur_ch + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (bus.sta) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_state_next = S_RUN;
      end
      S_FLUSH: begin
        // r_done is high on the cycle the last sample is presented.
        if (bus.sta) begin
          w_state_next = S_RUN;
        end else if (r_done) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    if (w_last) begin
      w_state_next = S_FLUSH;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: ordering key and NaN detect
  // ---------------------------------------------------------------------------
  assign w_din_key = f_key(bus.din);
  assign w_din_nan = (bus.din[30:23] == 8'hFF) && (bus.din[22:0] != 23'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_nan   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_din   <= 32'h0;
      r_s1_key   <= 32'h0;
      r_s1_ch    <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_nan  <= w_din_nan;
        r_s1_last <= w_last;
        r_s1_din  <= bus.din;
        r_s1_key  <= w_din_key;
        r_s1_ch   <= w_cur_ch;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: compare / select, counters, outputs
  // ---------------------------------------------------------------------------
  assign w_gt_hi  = r_s1_key > KEY_HI;
  assign w_lt_lo  = r_s1_key < KEY_LO;
  // NaN keys are meaningless, so NaN overrides both compares and goes low.
  assign w_sat_hi = !r_s1_nan && w_gt_hi;
  assign w_sat_lo = r_s1_nan || w_lt_lo;

  always_comb begin
    w_y = r_s1_din;
    if (w_sat_lo) begin
      w_y = LO;
    end else if (w_sat_hi) begin
      w_y = HI;
    end
  end

  assign w_sat_any  = r_s1_valid && (w_sat_hi || w_sat_lo);
  assign w_run_inc  = (w_sat_any && (r_run_cnt != 16'hFFFF)) ? (r_run_cnt + 16'd1) : r_run_cnt;
  // The last-channel tag travels with the sample, so a start pulse arriving
  // while it is still in flight does not cancel the step's completion.
  assign w_done_set = r_s1_valid && r_s1_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y         <= 32'h0;
      r_out_valid <= 1'b0;
      r_ch_idx    <= '0;
      r_sat_hi    <= 1'b0;
      r_sat_lo    <= 1'b0;
      r_nan_err   <= 1'b0;
      r_done      <= 1'b0;
      r_run_cnt   <= 16'h0;
      r_sat_cnt   <= 16'h0;
    end else begin
      r_out_valid <= r_s1_valid;
      r_done      <= w_done_set;
      if (r_s1_valid) begin
        r_y       <= w_y;
        r_ch_idx  <= r_s1_ch;
        r_sat_hi  <= w_sat_hi;
        r_sat_lo  <= w_sat_lo;
        r_nan_err <= r_nan_err | r_s1_nan;
      end
      // Final count includes the last sample's own saturation; a start pulse
      // on the same edge begins the next step from zero.
      if (w_done_set) begin
        r_sat_cnt <= w_run_inc;
      end
      r_run_cnt <= bus.sta ? 16'h0 : w_run_inc;
    end
  end

  assign bus.y         = r_y;
  assign bus.out_valid = r_out_valid;
  assign bus.ch_idx    = r_ch_idx;
  assign bus.sat_hi    = r_sat_hi;
  assign bus.sat_lo    = r_sat_lo;
  assign bus.nan_err   = r_nan_err;
  assign bus.sat_cnt   = r_sat_cnt;
  assign bus.done_sig  = r_done;

endmodule

// File: tb/tb_pid_output_limiter.sv
// -----------------------------------------------------------------------------
// tb_pid_output_limiter
// Drives pid_output_limiter through directed vectors, multi-cycle corner
// sequences and randomized steps; a real-valued reference model and an
// expected-output queue check every output cycle.
// -----------------------------------------------------------------------------
module tb_pid_output_limiter;
  localparam int          N_CH = 32;
  localparam int          CH_W = 6;
  localparam logic [31:0] HI   = 32'h3F800000;
  localparam logic [31:0] LO   = 32'hBF800000;
  localparam logic [31:0] HALF = 32'h3F000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pid_output_limiter_if #(.CH_W(CH_W)) bus ();

  pid_output_limiter #(
    .N_CH (N_CH),
    .CH_W (CH_W),
    .HI   (HI),
    .LO   (LO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0]     y;
    logic [CH_W-1:0] ch;
    logic            hi;
    logic            lo;
    logic            nan;
    logic            last;
    logic [15:0]     sat;
    int              cyc;
  } exp_t;

  typedef struct {
    logic [31:0] din;
    logic [31:0] y;
    logic        hi;
    logic        lo;
  } vec_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_done = 0;
  bit   mon_en = 1'b0;

  // step model state
  int   m_ch = 0;
  int   m_run = 0;
  bit   m_active = 1'b0;

  // expected held outputs
  logic [31:0]     exp_y = 32'h0;
  logic [CH_W-1:0] exp_ch = '0;
  logic            exp_hi = 1'b0;
  logic            exp_lo = 1'b0;
  logic            exp_nan = 1'b0;
  logic [15:0]     exp_sat = 16'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_nan(input logic [31:0] b);
    return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  endfunction

  function automatic real f2r(input logic [31:0] b);
    int  e;
    real m;
    real v;
    e = int'(b[30:23]);
    m = real'(b[22:0]);
    if (e == 255)    v = 1.0e300;
    else if (e == 0) v = m * (2.0 ** (-149.0));
    else             v = (1.0 + m / 8388608.0) * (2.0 ** real'(e - 127));
    return b[31] ? -v : v;
  endfunction

  task automatic model(input logic [31:0] d, output logic [31:0] y, output logic hi, output logic lo);
    real v;
    hi = 1'b0;
    lo = 1'b0;
    y  = d;
    if (is_nan(d)) begin
      y  = LO;
      lo = 1'b1;
    end else begin
      v = f2r(d);
      if (v > f2r(HI)) begin
        y  = HI;
        hi = 1'b1;
      end else if (v < f2r(LO)) begin
        y  = LO;
        lo = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] rnd_sample();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0:       r = $urandom;
      1:       r = 32'h3F7FFFF0 + 32'($urandom_range(0, 31));
      2:       r = 32'hBF7FFFF0 + 32'($urandom_range(0, 31));
      default: r = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 23'($urandom_range(0, 3))};
    endcase
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic cycle_x(input logic s, input logic v, input logic [31:0] d,
                         input logic [31:0] ey, input logic ehi, input logic elo);
    exp_t e;
    bus.sta      = s;
    bus.in_valid = v;
    bus.din      = d;
    if (s) begin
      m_ch     = 0;
      m_run    = 0;
      m_active = 1'b1;
    end
    if (v && m_active) begin
      e.y    = ey;
      e.ch   = m_ch[CH_W-1:0];
      e.hi   = ehi;
      e.lo   = elo;
      e.nan  = is_nan(d);
      e.last = (m_ch == N_CH - 1);
      e.cyc  = cyc + 2;
      if ((ehi || elo) && m_run < 65535) m_run++;
      e.sat  = m_run[15:0];
      q.push_back(e);
      m_ch++;
      if (e.last) m_active = 1'b0;
    end
    @(posedge clk);
    #1;
    bus.sta      = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic cycle_m(input logic s, input logic v, input logic [31:0] d);
    logic [31:0] ey;
    logic        ehi;
    logic        elo;
    model(d, ey, ehi, elo);
    cycle_x(s, v, d, ey, ehi, elo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_m(1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    bus.sta      = 1'b0;
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    q.delete();
    m_active = 1'b0;
    exp_y    = 32'h0;
    exp_ch   = '0;
    exp_hi   = 1'b0;
    exp_lo   = 1'b0;
    exp_nan  = 1'b0;
    exp_sat  = 16'h0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("latency",  cyc, e.cyc);
          chk("y",        bus.y, e.y);
          chk("ch_idx",   32'(bus.ch_idx), 32'(e.ch));
          chk("sat_hi",   32'(bus.sat_hi), 32'(e.hi));
          chk("sat_lo",   32'(bus.sat_lo), 32'(e.lo));
          chk("done_sig", 32'(bus.done_sig), 32'(e.last));
          exp_y  = e.y;
          exp_ch = e.ch;
          exp_hi = e.hi;
          exp_lo = e.lo;
          if (e.nan)  exp_nan = 1'b1;
          if (e.last) exp_sat = e.sat;
          $display("[TB] out cyc=%0d ch=%0d din->y=%h hi=%b lo=%b done=%b sat_cnt=%0d",
                   cyc, bus.ch_idx, bus.y, bus.sat_hi, bus.sat_lo, bus.done_sig, bus.sat_cnt);
        end
      end else begin
        chk("done_without_out", 32'(bus.done_sig), 32'd0);
        chk("y_hold",  bus.y, exp_y);
        chk("ch_hold", 32'(bus.ch_idx), 32'(exp_ch));
        chk("hi_hold", 32'(bus.sat_hi), 32'(exp_hi));
        chk("lo_hold", 32'(bus.sat_lo), 32'(exp_lo));
        if (q.size() != 0 && q[0].cyc <= cyc) begin
          chk("missing_out_valid", 32'(bus.out_valid), 32'd1);
          q.delete(0);
        end
      end
      if (bus.done_sig) n_done++;
      chk("sat_cnt", 32'(bus.sat_cnt), 32'(exp_sat));
      chk("nan_err", 32'(bus.nan_err), 32'(exp_nan));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    vec_t tbl[14];
    int   d0;

    tbl[0]  = '{32'h40000000, HI,           1'b1, 1'b0}; // 2.0
    tbl[1]  = '{32'hC0000000, LO,           1'b0, 1'b1}; // -2.0
    tbl[2]  = '{32'h7F800000, HI,           1'b1, 1'b0}; // +Inf
    tbl[3]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0}; // -0 bit-exact
    tbl[4]  = '{32'h3F800000, 32'h3F800000, 1'b0, 1'b0}; // exactly HI
    tbl[5]  = '{32'h7FC00000, LO,           1'b0, 1'b1}; // qNaN
    tbl[6]  = '{32'hBF800000, 32'hBF800000, 1'b0, 1'b0}; // exactly LO
    tbl[7]  = '{32'hFF800000, LO,           1'b0, 1'b1}; // -Inf
    tbl[8]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b0}; // +0
    tbl[9]  = '{32'hBF800001, LO,           1'b0, 1'b1}; // just below LO
    tbl[10] = '{32'h3F800001, HI,           1'b1, 1'b0}; // just above HI
    tbl[11] = '{32'h7F800001, LO,           1'b0, 1'b1}; // sNaN
    tbl[12] = '{32'h00000001, 32'h00000001, 1'b0, 1'b0}; // denormal
    tbl[13] = '{32'hFFFFFFFF, LO,           1'b0, 1'b1}; // negative NaN

    bus.sta      = 1'b0;
    bus.in_valid = 1'b0;
    bus.din      = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("rst_y",         bus.y, 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ch_idx",    32'(bus.ch_idx), 32'd0);
    chk("rst_flags",     32'({bus.sat_hi, bus.sat_lo, bus.nan_err, bus.done_sig}), 32'd0);
    chk("rst_sat_cnt",   32'(bus.sat_cnt), 32'd0);
    mon_en = 1'b1;

    // Pass-through step: 32 x 0.5 back to back
    cycle_m(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < N_CH; i++) cycle_x(1'b0, 1'b1, HALF, HALF, 1'b0, 1'b0);
    idle(4);
    chk("pass_done_count", n_done, 1);

    // Directed compare-rule vectors, padded with random channels
    cycle_m(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 14; i++) cycle_x(1'b0, 1'b1, tbl[i].din, tbl[i].y, tbl[i].hi, tbl[i].lo);
    while (m_active) cycle_m(1'b0, 1'b1, rnd_sample());
    idle(4);
    chk("table_done_count", n_done, 2);

    // Bubbles: in_valid toggling 1010... over 64 cycles
    cycle_m(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 2 * N_CH; i++) cycle_x(1'b0, (i % 2) == 0, HALF, HALF, 1'b0, 1'b0);
    idle(4);
    chk("bubble_done_count", n_done, 3);

    // Randomized steps: random bubbles, random gaps (0 gap = sta during FLUSH),
    // stray in_valid while idle, sample sometimes arriving with sta
    for (int s = 0; s < 8; s++) begin
      cycle_m(1'b1, $urandom_range(0, 1) == 1, rnd_sample());
      while (m_active) cycle_m(1'b0, $urandom_range(0, 3) != 0, rnd_sample());
      for (int g = 0; g < int'($urandom_range(0, 3)); g++)
        cycle_m(1'b0, $urandom_range(0, 1) == 1, rnd_sample());
    end
    idle(4);
    chk("random_done_count", n_done, 11);

    // Restart: sta together with the 11th sample
    d0 = n_done;
    cycle_m(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) cycle_m(1'b0, 1'b1, rnd_sample());
    cycle_m(1'b1, 1'b1, rnd_sample());
    for (int i = 0; i < N_CH - 2; i++) cycle_m(1'b0, 1'b1, rnd_sample());
    idle(3);
    chk("restart_no_early_done", n_done, d0);
    cycle_m(1'b0, 1'b1, rnd_sample());
    idle(4);
    chk("restart_done_count", n_done, d0 + 1);

    // Reset mid-step at sample 20, then idle ignores in_valid until sta
    d0 = n_done;
    cycle_m(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++) cycle_m(1'b0, 1'b1, rnd_sample());
    do_reset();
    chk("midrst_y",       bus.y, 32'h0);
    chk("midrst_sat_cnt", 32'(bus.sat_cnt), 32'd0);
    for (int i = 0; i < 8; i++) cycle_m(1'b0, 1'b1, rnd_sample());
    idle(3);
    chk("midrst_no_done", n_done, d0);
    cycle_m(1'b1, 1'b1, rnd_sample());
    while (m_active) cycle_m(1'b0, 1'b1, rnd_sample());
    idle(4);
    chk("recover_done_count", n_done, d0 + 1);
    chk("queue_drained", q.size(), 0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
